// File: rtl/sd_spi_xfer_engine.sv
// SPI-mode SD command/response engine with integrated SCLK divider.
// Runs the power-up dummy-clock sequence, shifts out CMD_BYTES-byte commands,
// hunts for the R1 start byte and streams the requested number of response bytes.
// Optional feature macro: SD_SPI_CRC7_EN replaces the last command byte with
// {CRC7(bytes 0..CMD_BYTES-2), 1'b1}; when undefined cmd_data is sent verbatim.
module sd_spi_xfer_engine #(
    parameter int unsigned CMD_BYTES = 6,
    parameter int unsigned MAX_RESP  = 520,
    parameter int unsigned HALF_SLOW = 64,
    parameter int unsigned HALF_FAST = 1,
    parameter int unsigned INIT_CLKS = 80,
    parameter int unsigned NCR_MAX   = 8
) (
    input  logic                   clk,
    input  logic                   res_n,
    input  logic                   speed,
    input  logic                   init_req,
    input  logic                   cmd_valid,
    input  logic [8*CMD_BYTES-1:0] cmd_data,
    input  logic [9:0]             resp_bytes,
    output logic                   busy,
    output logic                   error,
    output logic [7:0]             resp_data,
    output logic                   resp_valid,
    output logic                   done,
    output logic                   card_sclk,
    output logic                   card_mosi,
    input  logic                   card_miso,
    output logic                   card_cs
);

    localparam int unsigned FRAME_W = 8 * CMD_BYTES;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_INIT, ST_CMD, ST_WAIT_R1, ST_RESP, ST_GAP, ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               speed_q, speed_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               mosi_q, mosi_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic [2:0]         bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic               done_q, done_d;
    logic               resp_valid_q, resp_valid_d;
    logic [7:0]         resp_data_q, resp_data_d;

    logic               active, tick, rise, fall;
    logic [FRAME_W-1:0] cmd_frame;
    logic [7:0]         rx_byte;
    logic [CNT_W-1:0]   total_c;

    // Command frame as it goes on the wire (optionally with generated CRC7)
    function automatic logic [FRAME_W-1:0] build_frame(input logic [FRAME_W-1:0] f);
`ifdef SD_SPI_CRC7_EN
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = FRAME_W - 1; i >= 8; i--) begin
            fb  = crc[6] ^ f[i];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        build_frame = {f[FRAME_W-1:8], crc, 1'b1};
`else
        build_frame = f;
`endif
    endfunction

    assign active    = state_q inside {ST_INIT, ST_CMD, ST_WAIT_R1, ST_RESP, ST_GAP};
    assign tick      = active && (div_q == '0);
    assign rise      = tick && !sclk_q;
    assign fall      = tick && sclk_q;
    assign cmd_frame = build_frame(cmd_data);
    assign rx_byte   = {rx_q[6:0], card_miso};
    assign total_c   = (resp_bytes == '0) ? CNT_W'(1) :
                       (resp_bytes > CNT_W'(MAX_RESP)) ? CNT_W'(MAX_RESP) : resp_bytes;

    // Next-state, divider, shifter and registered-output computation
    always_comb begin
        state_d      = state_q;
        speed_d      = speed_q;
        div_d        = div_q;
        sclk_d       = sclk_q;
        cs_d         = cs_q;
        mosi_d       = mosi_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        total_d      = total_q;
        error_d      = error_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;

        if (active) begin
            if (tick) begin
                div_d  = speed_q ? DIV_W'(HALF_FAST - 1) : DIV_W'(HALF_SLOW - 1);
                sclk_d = !sclk_q;
            end else begin
                div_d = div_q - DIV_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (init_req || cmd_valid) begin
                    speed_d = speed;
                    div_d   = speed ? DIV_W'(HALF_FAST - 1) : DIV_W'(HALF_SLOW - 1);
                    sclk_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    error_d = 1'b0;
                    total_d = total_c;
                    if (init_req) begin
                        state_d = ST_INIT;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b1;
                    end else begin
                        state_d = ST_CMD;
                        tx_d    = cmd_frame;
                        cs_d    = 1'b0;
                        mosi_d  = cmd_frame[FRAME_W-1];
                    end
                end
            end
            ST_INIT: begin
                if (fall) begin
                    if (cnt_q == CNT_W'(INIT_CLKS - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CMD: begin
                if (fall) begin
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        state_d = ST_WAIT_R1;
                        cnt_d   = '0;
                        bit_d   = '0;
                        mosi_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        tx_d   = {tx_q[FRAME_W-2:0], tx_q[FRAME_W-1]};
                        mosi_d = tx_q[FRAME_W-2];
                    end
                end
            end
            ST_WAIT_R1, ST_RESP: begin
                // Capture on the rising edge; a byte is delivered after its 8th sample
                if (rise) begin
                    rx_d = rx_byte;
                    if (bit_q == 3'd7) begin
                        if (state_q == ST_RESP || !rx_byte[7]) begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = rx_byte;
                            cnt_d        = (state_q == ST_RESP) ? cnt_q + CNT_W'(1) : CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                // Phase changes happen on the falling edge that closes a byte
                if (fall) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        if (state_q == ST_WAIT_R1) begin
                            if (!rx_q[7]) begin
                                if (cnt_q >= total_q) begin
                                    state_d = ST_GAP;
                                    cnt_d   = '0;
                                    cs_d    = 1'b1;
                                end else begin
                                    state_d = ST_RESP;
                                end
                            end else if (cnt_q == CNT_W'(NCR_MAX)) begin
                                state_d = ST_GAP;
                                cnt_d   = '0;
                                cs_d    = 1'b1;
                                error_d = 1'b1;
                            end
                        end else if (cnt_q == total_q) begin
                            state_d = ST_GAP;
                            cnt_d   = '0;
                            cs_d    = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (fall) begin
                    if (cnt_q == CNT_W'(7)) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= ST_IDLE;
            speed_q      <= 1'b0;
            div_q        <= '0;
            sclk_q       <= 1'b0;
            cs_q         <= 1'b1;
            mosi_q       <= 1'b1;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            total_q      <= '0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            speed_q      <= speed_d;
            div_q        <= div_d;
            sclk_q       <= sclk_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            total_q      <= total_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            done_q       <= done_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign busy       = busy_q;
    assign error      = error_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign done       = done_q;
    assign card_sclk  = sclk_q;
    assign card_mosi  = mosi_q;
    assign card_cs    = cs_q;

endmodule

// File: tb/tb_sd_spi_xfer_engine.sv
// Bench for sd_spi_xfer_engine: SD card model on the SPI pins plus a
// scoreboard of expected response bytes and end-of-request error flags.
module tb_sd_spi_xfer_engine;

    logic        clk;
    logic        res_n;
    logic        speed;
    logic        init_req;
    logic        cmd_valid;
    logic [47:0] cmd_data;
    logic [9:0]  resp_bytes;
    logic        busy;
    logic        error;
    logic [7:0]  resp_data;
    logic        resp_valid;
    logic        done;
    logic        card_sclk;
    logic        card_mosi;
    logic        card_miso;
    logic        card_cs;

    int checks;
    int failures;

    logic [7:0] exp_resp[$];
    logic       exp_done[$];
    logic [7:0] card_q[$];
    time        resp_times[$];

    int          rx_bits;
    logic [47:0] rx_frame;
    logic [47:0] last_frame;
    int          frames_seen;
    logic [7:0]  out_sr;
    int          out_cnt;
    int          rises;
    int          cs_low_rises;
    int          mosi_bad;
    int          per_bad;
    bit          rise_valid;
    time         last_rise;
    time         period_exp;
    int          resp_seen;

`ifdef SD_SPI_CRC7_EN
    localparam logic [7:0] EXP_CRC_BYTE = 8'h87;
`else
    localparam logic [7:0] EXP_CRC_BYTE = 8'h00;
`endif

    sd_spi_xfer_engine dut (
        .clk        (clk),
        .res_n      (res_n),
        .speed      (speed),
        .init_req   (init_req),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .resp_bytes (resp_bytes),
        .busy       (busy),
        .error      (error),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .done       (done),
        .card_sclk  (card_sclk),
        .card_mosi  (card_mosi),
        .card_miso  (card_miso),
        .card_cs    (card_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Card model: sample MOSI on SCLK rise, collect the command, time pulses
    always @(posedge card_sclk) begin
        rises++;
        if (card_cs) begin
            if (!card_mosi) mosi_bad++;
        end else begin
            cs_low_rises++;
            if (rx_bits < 48) begin
                rx_frame = {rx_frame[46:0], card_mosi};
                rx_bits++;
                if (rx_bits == 48) begin
                    last_frame = rx_frame;
                    frames_seen++;
                end
            end
        end
        if (rise_valid && (($time - last_rise) != period_exp)) per_bad++;
        last_rise  = $time;
        rise_valid = 1'b1;
    end

    // Card model: present response bits on SCLK fall once the command is in
    always @(negedge card_sclk) begin
        if (!card_cs && rx_bits >= 48) begin
            if (out_cnt == 0) begin
                if (card_q.size() > 0) out_sr = card_q.pop_front();
                else                   out_sr = 8'hFF;
                out_cnt = 8;
            end
            card_miso = out_sr[7];
            out_sr    = {out_sr[6:0], 1'b0};
            out_cnt--;
        end
    end

    // Card model: deselect resets the card-side shifters
    always @(posedge card_cs) begin
        rx_bits   = 0;
        out_cnt   = 0;
        card_miso = 1'b1;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (res_n) begin
            if (resp_valid) begin
                resp_seen++;
                resp_times.push_back($time);
                checks++;
                if (exp_resp.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected actual=%02h required=no_strobe", resp_data);
                end else begin
                    logic [7:0] e;
                    e = exp_resp.pop_front();
                    if (resp_data !== e) begin
                        failures++;
                        $display("FAIL resp_data actual=%02h required=%02h", resp_data, e);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    logic e;
                    e = exp_done.pop_front();
                    if (error !== e) begin
                        failures++;
                        $display("FAIL done_error actual=%0b required=%0b", error, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic ini, input logic cmd, input logic spd,
                         input logic [47:0] data, input logic [9:0] rb);
        @(negedge clk);
        init_req   = ini;
        cmd_valid  = cmd;
        speed      = spd;
        cmd_data   = data;
        resp_bytes = rb;
        @(negedge clk);
        init_req  = 1'b0;
        cmd_valid = 1'b0;
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_error_clear", 64'(error), 64'd0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    endtask

    task automatic arm_timing(input time period);
        period_exp   = period;
        rise_valid   = 1'b0;
        rises        = 0;
        cs_low_rises = 0;
        mosi_bad     = 0;
        per_bad      = 0;
    endtask

    initial begin
        int f0;
        int r0;
        checks      = 0;
        failures    = 0;
        res_n       = 1'b0;
        speed       = 1'b0;
        init_req    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = '0;
        resp_bytes  = '0;
        card_miso   = 1'b1;
        rx_bits     = 0;
        rx_frame    = '0;
        last_frame  = '0;
        frames_seen = 0;
        out_sr      = 8'hFF;
        out_cnt     = 0;
        resp_seen   = 0;
        arm_timing(20);
        repeat (3) @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_cs", 64'(card_cs), 64'd1);

        // T1: asynchronous reset in the middle of a command
        issue(1'b0, 1'b1, 1'b1, 48'h400000000095, 10'd1);
        repeat (20) @(negedge clk);
        #2 res_n = 1'b0;
        #1;
        chk("rst_cs", 64'(card_cs), 64'd1);
        chk("rst_sclk", 64'(card_sclk), 64'd0);
        chk("rst_mosi", 64'(card_mosi), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        res_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_sclk", 64'(card_sclk), 64'd0);
        chk("post_rst_frames", 64'(frames_seen), 64'd0);

        // T2: init sequence at slow speed; simultaneous cmd_valid must lose
        arm_timing(1280);
        f0 = frames_seen;
        exp_done.push_back(1'b0);
        issue(1'b1, 1'b1, 1'b0, 48'h510000000055, 10'd1);
        wait_done(20000);
        chk("init_pulses", 64'(rises), 64'd88);
        chk("init_period", 64'(per_bad), 64'd0);
        chk("init_cs_high", 64'(cs_low_rises), 64'd0);
        chk("init_mosi_high", 64'(mosi_bad), 64'd0);
        chk("init_no_cmd", 64'(frames_seen), 64'(f0));
        chk("init_error", 64'(error), 64'd0);

        // T3: CMD0 at slow speed, R1 after two fill bytes
        arm_timing(1280);
        r0 = resp_seen;
        card_q.push_back(8'hFF);
        card_q.push_back(8'hFF);
        card_q.push_back(8'h01);
        exp_resp.push_back(8'h01);
        exp_done.push_back(1'b0);
        issue(1'b0, 1'b1, 1'b0, 48'h400000000095, 10'd1);
        wait_done(20000);
        chk("cmd0_frame", 64'(last_frame), 64'h400000000095);
        chk("cmd0_resp_count", 64'(resp_seen - r0), 64'd1);
        chk("cmd0_period", 64'(per_bad), 64'd0);
        chk("cmd0_gap_mosi", 64'(mosi_bad), 64'd0);

        // T4: no R1 ever arrives
        arm_timing(20);
        card_q.delete();
        r0 = resp_seen;
        exp_done.push_back(1'b1);
        issue(1'b0, 1'b1, 1'b1, 48'h4D0000000001, 10'd1);
        wait_done(2000);
        chk("timeout_resp_count", 64'(resp_seen - r0), 64'd0);
        repeat (5) @(negedge clk);
        chk("timeout_error_sticky", 64'(error), 64'd1);

        // T5: CMD8 with R7 at fast speed; requests while busy ignored
        arm_timing(20);
        f0 = frames_seen;
        r0 = resp_seen;
        resp_times.delete();
        card_q.push_back(8'h01);
        card_q.push_back(8'h00);
        card_q.push_back(8'h00);
        card_q.push_back(8'h01);
        card_q.push_back(8'hAA);
        exp_resp.push_back(8'h01);
        exp_resp.push_back(8'h00);
        exp_resp.push_back(8'h00);
        exp_resp.push_back(8'h01);
        exp_resp.push_back(8'hAA);
        exp_done.push_back(1'b0);
        issue(1'b0, 1'b1, 1'b1, 48'h48000001AA87, 10'd5);
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(negedge clk);
            cmd_valid = 1'b1;
            cmd_data  = 48'h7700000000FF;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        wait_done(2000);
        chk("r7_frames", 64'(frames_seen - f0), 64'd1);
        chk("r7_frame", 64'(last_frame), 64'h48000001AA87);
        chk("r7_resp_count", 64'(resp_seen - r0), 64'd5);
        chk("r7_period", 64'(per_bad), 64'd0);
        if (resp_times.size() == 5) begin
            for (int k = 1; k < 5; k++)
                chk("r7_strobe_spacing", 64'(resp_times[k] - resp_times[k-1]), 64'd160);
        end
        repeat (20) @(negedge clk);
        chk("r7_stays_idle", 64'(busy), 64'd0);

        // T6: CRC byte handling; resp_bytes=0 behaves as 1
        arm_timing(20);
        r0 = resp_seen;
        card_q.delete();
        card_q.push_back(8'h01);
        exp_resp.push_back(8'h01);
        exp_done.push_back(1'b0);
        issue(1'b0, 1'b1, 1'b1, 48'h48000001AA00, 10'd0);
        wait_done(2000);
        chk("crc_body", 64'(last_frame[47:8]), 64'h48000001AA);
        chk("crc_byte", 64'(last_frame[7:0]), 64'(EXP_CRC_BYTE));
        chk("crc_resp_count", 64'(resp_seen - r0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
